// File: rtl/scan_decode.sv
// Observer-side decoder for the 3-digit multiplexed scan bus: reassembles {d2,d1,d0},
// checks digit order and step timing, and publishes a word once it repeats STABLE times.
module scan_decode #(
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [2:0]  scan_en,
    input  logic [3:0]  scan_data,
    output logic [11:0] dataout,
    output logic        valid,
    output logic        err
);
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
    localparam logic [3:0] LP_STABLE  = 4'(STABLE);

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        GOT0  = 2'd1,
        GOT1  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_s_en;
    logic [2:0]  r_p_en;
    logic [3:0]  r_s_data;
    logic [3:0]  r_d0;
    logic [3:0]  r_d1;
    logic [11:0] r_cand;
    logic [11:0] r_dataout;
    logic [3:0]  r_cnt;
    logic [7:0]  r_idle;
    logic        r_valid;
    logic        r_err;

    logic        w_step;
    logic        w_onehot;
    logic        w_timeout;
    logic        w_err;
    logic        w_cap0;
    logic        w_cap1;
    logic        w_done;
    logic        w_clr_cnt;
    logic [7:0]  w_idle_inc;
    logic [11:0] w_frame;
    logic        w_same;
    logic [3:0]  w_cnt_next;
    logic        w_publish;

    assign w_step     = (r_s_en != r_p_en);
    assign w_onehot   = (r_s_en == 3'b001) || (r_s_en == 3'b010) || (r_s_en == 3'b100);
    assign w_idle_inc = (r_idle == LP_TIMEOUT) ? r_idle : r_idle + 8'd1;
    // The timeout fires on the cycle the idle count would reach TIMEOUT, only mid-frame.
    assign w_timeout  = !w_step && (r_state != WAIT0) && (w_idle_inc == LP_TIMEOUT);
    assign w_frame    = {r_s_data, r_d1, r_d0};
    assign w_same     = (w_frame == r_cand);

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_cap0       = 1'b0;
        w_cap1       = 1'b0;
        w_done       = 1'b0;
        w_clr_cnt    = 1'b0;
        if (w_step) begin
            if (!w_onehot) begin
                w_err        = 1'b1;
                w_clr_cnt    = 1'b1;
                w_state_next = WAIT0;
            end else begin
                case (r_state)
                    WAIT0: begin
                        if (r_s_en == 3'b001) begin
                            w_cap0       = 1'b1;
                            w_state_next = GOT0;
                        end
                    end
                    GOT0: begin
                        if (r_s_en == 3'b010) begin
                            w_cap1       = 1'b1;
                            w_state_next = GOT1;
                        end else if (r_s_en == 3'b100) begin
                            w_err        = 1'b1;
                            w_state_next = WAIT0;
                        end else begin
                            w_cap0 = 1'b1;
                        end
                    end
                    GOT1: begin
                        if (r_s_en == 3'b100) begin
                            w_done       = 1'b1;
                            w_state_next = WAIT0;
                        end else if (r_s_en == 3'b001) begin
                            w_err        = 1'b1;
                            w_cap0       = 1'b1;
                            w_state_next = GOT0;
                        end
                    end
                    default: w_state_next = WAIT0;
                endcase
            end
        end else if (w_timeout) begin
            w_err        = 1'b1;
            w_clr_cnt    = 1'b1;
            w_state_next = WAIT0;
        end
    end

    // Publish only on the transition into STABLE, never while already saturated.
    always_comb begin
        w_cnt_next = r_cnt;
        w_publish  = 1'b0;
        if (w_clr_cnt) begin
            w_cnt_next = 4'd0;
        end else if (w_done) begin
            if (w_same) begin
                if (r_cnt != LP_STABLE) begin
                    w_cnt_next = r_cnt + 4'd1;
                    w_publish  = (r_cnt + 4'd1 == LP_STABLE);
                end
            end else begin
                w_cnt_next = 4'd1;
                w_publish  = (LP_STABLE == 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= WAIT0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_s_en    <= 3'b000;
            r_p_en    <= 3'b000;
            r_s_data  <= 4'd0;
            r_d0      <= 4'd0;
            r_d1      <= 4'd0;
            r_cand    <= 12'd0;
            r_cnt     <= 4'd0;
            r_idle    <= 8'd0;
            r_dataout <= 12'd0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_s_en   <= scan_en;
            r_s_data <= scan_data;
            r_p_en   <= r_s_en;
            r_idle   <= (w_step || w_timeout) ? 8'd0 : w_idle_inc;
            if (w_cap0) r_d0 <= r_s_data;
            if (w_cap1) r_d1 <= r_s_data;
            r_cnt <= w_cnt_next;
            if (w_done && !w_same) r_cand <= w_frame;
            if (w_publish) r_dataout <= w_frame;
            r_valid <= w_publish;
            r_err   <= w_err;
        end
    end

    assign dataout = r_dataout;
    assign valid   = r_valid;
    assign err     = r_err;

endmodule

// File: tb/tb_scan_decode.sv
// Bench for scan_decode: directed vector table, hand-written corner sequences and
// randomized bus traffic, all compared against a digit-position reference model.
module tb_scan_decode;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  scan_en;
    logic [3:0]  scan_data;
    logic [11:0] dataout;
    logic        valid;
    logic        err;

    always #5 clk = ~clk;

    scan_decode #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clr       (clr),
        .scan_en   (scan_en),
        .scan_data (scan_data),
        .dataout   (dataout),
        .valid     (valid),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [2:0] last_en = 3'b000;
    logic [3:0] last_data = 4'd0;
    logic [11:0] exp_q[$];

    // Reference model: phase = index of the digit expected next (0..2).
    logic [2:0]  m_s_en = 3'b000;
    logic [2:0]  m_p_en = 3'b000;
    logic [3:0]  m_s_data = 4'd0;
    int          m_phase = 0;
    int          m_idle = 0;
    int          m_cnt = 0;
    logic [3:0]  m_dig[3];
    logic [11:0] m_cand = 12'd0;
    logic [11:0] m_dout = 12'd0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dig_of(input logic [2:0] e);
        case (e)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_publish(input logic [11:0] frame);
        m_dout  = frame;
        m_valid = 1'b1;
        exp_q.push_back(frame);
    endtask

    task automatic model_frame(input logic [11:0] frame);
        if (frame == m_cand) begin
            if (m_cnt < STABLE) begin
                m_cnt++;
                if (m_cnt == STABLE) model_publish(frame);
            end
        end else begin
            m_cand = frame;
            m_cnt  = 1;
            if (STABLE == 1) model_publish(frame);
        end
    endtask

    task automatic model_clock(input logic [2:0] en, input logic [3:0] data, input logic c);
        int d;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (c) begin
            m_s_en = 3'b000; m_p_en = 3'b000; m_s_data = 4'd0;
            m_phase = 0; m_idle = 0; m_cnt = 0; m_cand = 12'd0; m_dout = 12'd0;
            for (int i = 0; i < 3; i++) m_dig[i] = 4'd0;
            return;
        end
        if (m_s_en != m_p_en) begin
            m_idle = 0;
            d = dig_of(m_s_en);
            if (d < 0) begin
                m_err = 1'b1; m_phase = 0; m_cnt = 0;
            end else if (d == 0) begin
                m_err = (m_phase == 2);
                m_dig[0] = m_s_data;
                m_phase = 1;
            end else if (d == m_phase) begin
                m_dig[d] = m_s_data;
                if (d == 2) begin
                    m_phase = 0;
                    model_frame({m_dig[2], m_dig[1], m_dig[0]});
                end else begin
                    m_phase = 2;
                end
            end else if (m_phase == 1) begin
                m_err = 1'b1;
                m_phase = 0;
            end
        end else begin
            m_idle = (m_idle < TIMEOUT) ? m_idle + 1 : TIMEOUT;
            if (m_phase != 0 && m_idle == TIMEOUT) begin
                m_err = 1'b1; m_phase = 0; m_cnt = 0; m_idle = 0;
            end
        end
        m_p_en   = m_s_en;
        m_s_en   = en;
        m_s_data = data;
    endtask

    task automatic tick(input logic [2:0] en, input logic [3:0] data, input logic c);
        @(negedge clk);
        scan_en = en; scan_data = data; clr = c;
        last_en = en; last_data = data;
        @(posedge clk);
        model_clock(en, data, c);
        #1;
        check("valid", 32'(valid), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
        check("dataout", 32'(dataout), 32'(m_dout));
        if (valid) begin
            n_valid++;
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sb_word", 32'(dataout), 32'(exp_q.pop_front()));
        end
        if (err) n_err++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(last_en, last_data, 1'b0);
    endtask

    task automatic send_frame(input logic [11:0] w, input int hold);
        for (int i = 0; i < hold; i++) tick(3'b001, w[3:0], 1'b0);
        for (int i = 0; i < hold; i++) tick(3'b010, w[7:4], 1'b0);
        for (int i = 0; i < hold; i++) tick(3'b100, w[11:8], 1'b0);
    endtask

    typedef struct {
        logic [2:0]  en;
        logic [3:0]  data;
        logic        c;
        logic        ev;
        logic        ee;
        logic [11:0] ed;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int snap_v;
        int snap_e;
        logic [11:0] words[4];
        clr = 1'b1; scan_en = 3'b000; scan_data = 4'd0;
        for (int i = 0; i < 3; i++) m_dig[i] = 4'd0;

        // Expected outputs are those visible just after the edge that samples the row.
        tbl[0]  = '{3'b000, 4'h0, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[1]  = '{3'b001, 4'h3, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[2]  = '{3'b010, 4'h2, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[3]  = '{3'b100, 4'h1, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[4]  = '{3'b001, 4'h3, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[5]  = '{3'b010, 4'h2, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[6]  = '{3'b100, 4'h1, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[7]  = '{3'b001, 4'h3, 1'b0, 1'b1, 1'b0, 12'h123};
        tbl[8]  = '{3'b010, 4'h2, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[9]  = '{3'b100, 4'h1, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[10] = '{3'b100, 4'h1, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[11] = '{3'b100, 4'h1, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[12] = '{3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[13] = '{3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 12'h123};
        tbl[14] = '{3'b011, 4'h5, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[15] = '{3'b011, 4'h5, 1'b0, 1'b0, 1'b1, 12'h123};
        tbl[16] = '{3'b011, 4'h5, 1'b0, 1'b0, 1'b0, 12'h123};

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].en, tbl[i].data, tbl[i].c);
            check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].ee));
            check($sformatf("tbl%0d_dataout", i), 32'(dataout), 32'(tbl[i].ed));
        end

        // Two words, two repeats each, digits held 3 cycles.
        tick(3'b000, 4'h0, 1'b1);
        snap_v = n_valid;
        send_frame(12'h123, 3);
        send_frame(12'h123, 3);
        idle(3);
        check("hold3_first_word", 32'(dataout), 32'h123);
        send_frame(12'h456, 3);
        send_frame(12'h456, 3);
        idle(3);
        check("hold3_second_word", 32'(dataout), 32'h456);
        check("hold3_pulses", 32'(n_valid - snap_v), 32'd2);

        // Skipped digit1 is an order error; then a clean word publishes.
        snap_e = n_err;
        tick(3'b001, 4'h9, 1'b0);
        tick(3'b100, 4'h7, 1'b0);
        idle(3);
        check("order_err_count", 32'(n_err - snap_e), 32'd1);
        send_frame(12'h789, 1);
        send_frame(12'h789, 1);
        idle(3);
        check("resync_word", 32'(dataout), 32'h789);

        // Mid-frame stall times out once; parking on digit2 in WAIT0 never does.
        snap_e = n_err;
        tick(3'b001, 4'h5, 1'b0);
        idle(TIMEOUT + 4);
        check("timeout_once", 32'(n_err - snap_e), 32'd1);
        snap_e = n_err;
        tick(3'b100, 4'h1, 1'b0);
        idle(40);
        check("wait0_no_timeout", 32'(n_err - snap_e), 32'd0);

        // Reset while in GOT1 discards everything; two fresh frames are needed.
        send_frame(12'hABC, 1);
        tick(3'b001, 4'hC, 1'b0);
        tick(3'b010, 4'hB, 1'b0);
        tick(3'b010, 4'hB, 1'b0);
        tick(3'b000, 4'h0, 1'b1);
        check("clr_dataout", 32'(dataout), 32'h000);
        check("clr_valid", 32'(valid), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        snap_v = n_valid;
        send_frame(12'hABC, 1);
        idle(3);
        check("clr_one_frame_no_pub", 32'(n_valid - snap_v), 32'd0);
        send_frame(12'hABC, 1);
        idle(3);
        check("clr_two_frames_pub", 32'(n_valid - snap_v), 32'd1);
        check("clr_word", 32'(dataout), 32'hABC);

        // Randomized traffic: repeated words, glitches, long stalls, occasional reset.
        words[0] = 12'h111; words[1] = 12'h2A5; words[2] = 12'hF0F; words[3] = 12'h3C7;
        for (int f = 0; f < 250; f++) begin
            logic [11:0] w;
            w = words[$urandom_range(0, 3)];
            if ($urandom_range(0, 49) == 0) tick(3'b000, 4'h0, 1'b1);
            for (int dg = 0; dg < 3; dg++) begin
                logic [2:0] e;
                int hold;
                e = 3'b001 << dg;
                if ($urandom_range(0, 15) == 0) e = 3'($urandom_range(0, 7));
                hold = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 22) : $urandom_range(1, 3);
                for (int h = 0; h < hold; h++) tick(e, 4'((w >> (4 * dg)) & 12'hF), 1'b0);
            end
        end
        idle(4);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_decode.md
# scan_decode

Receive-side decoder for the 3-digit multiplexed display scan bus (`scan_en` one-hot digit select plus `scan_data` 4-bit digit value) driven by the `scan` block. It reassembles the time-multiplexed digits into a 12-bit word, checks frame ordering and timing, and publishes a word only after it has seen that word repeat in consecutive complete frames. It sits on the observer side of the scan bus, for self-check, loopback test and readback of displayed values.

## Interface
- `STABLE`, 2: consecutive identical complete frames required before publishing (1..15).
- `TIMEOUT`, 16: maximum cycles without a digit step while a frame is in progress (2..255).

- `clk` in 1: single clock.
- `clr` in 1: reset. Synchronous, active-high.
- `scan_en` in 3: digit select. One-hot: 001 = digit0 (bits 3:0), 010 = digit1 (7:4), 100 = digit2 (11:8).
- `scan_data` in 4: value of the currently selected digit.
- `dataout` out 12: last published word {d2,d1,d0}.
- `valid` out 1: one-cycle pulse when `dataout` is updated.
- `err` out 1: one-cycle pulse on a protocol violation or timeout.

## Operation
- Input stage: `scan_en` and `scan_data` are registered every cycle into `s_en`/`s_data`. `p_en` holds the previous `s_en`. A step occurs when `s_en != p_en`. All decoding acts on step cycles only. Holding the same enable for many cycles is legal and captures nothing further.
- Illegal enable: on a step, a `s_en` of 000 or any multi-hot value means `err` is pulsed, the FSM goes to WAIT0, and the match count is cleared.
- FSM states: WAIT0, GOT0, GOT1.
  - WAIT0: a step to 001 captures d0 and goes to GOT0. A step to 010 or 100 stays in WAIT0 with no error; this is resynchronisation.
  - GOT0: a step to 010 captures d1 and goes to GOT1. A step to 100 pulses `err` and goes to WAIT0.
  - GOT1: a step to 100 completes the frame {`s_data`, d1, d0} and goes to WAIT0. A step to 001 pulses `err`, captures d0 and goes to GOT0.
- Timeout: an idle counter clears on every step and increments otherwise, saturating. If it reaches `TIMEOUT` while in GOT0 or GOT1, `err` is pulsed, the FSM goes to WAIT0, the match count is cleared and the counter is cleared. In WAIT0 the timeout never fires.
- Stability filter, applied on frame completion:
  - If the frame equals `cand`, the count increments, saturating at `STABLE`.
  - Otherwise `cand` takes the frame and the count becomes 1.
  - When the count transitions to `STABLE` (with `STABLE`=1, on every new-candidate frame), `dataout` takes the frame and `valid` is pulsed.
  - Further identical frames at saturation produce no pulse.
- `err` and `valid` never assert in the same cycle. An error cycle never completes a frame.
- Reset (`clr`=1 at a clock edge, including mid-frame):
  - `dataout`=0, `valid`=0, `err`=0.
  - FSM=WAIT0, `s_en`=`p_en`=000, `s_data`=0, `cand`=0, count=0, idle counter=0.
  - The partial frame is discarded.

## Timing
- Input `scan_en` present at edge k is in `s_en` after edge k. The step is evaluated in the following cycle, and registered outputs update at edge k+1. `valid`/`err` are therefore high for exactly the cycle after edge k+1. Latency is 2 edges from input to pulse.
- The bus may change every clock. Back-to-back steps every cycle must be decoded without loss.
- `dataout` holds its value between publishes and changes only together with `valid`.

## Test plan
- Reset then three frames of 0x123 (001/3, 010/2, 100/1, each held 1 cycle), with `STABLE`=2: `valid` pulses once, on the second frame's 100 step plus 2 edges. `dataout`=0x123. No `err`. No second pulse on the third frame.
- Frames 0x123 twice, then 0x456 twice, each digit held 3 cycles: `dataout` is 0x123 then 0x456, with exactly two `valid` pulses.
- Sequence 001, 100: one `err` pulse, no frame. A following 001, 010, 100 of 0x789, repeated twice, publishes 0x789.
- Illegal enables 000 and 011 on a step: `err` pulses each time, the match count clears, and `dataout` is unchanged.
- Hold 001 for `TIMEOUT` cycles after the step: `err` pulses once. Holding 100 in WAIT0 indefinitely: no `err`.
- Assert `clr` during GOT1 after one good frame: all outputs 0. The next two frames are needed to publish.
